// File: rtl/lrf_echo_emulator.sv
// Target-side echo emulator: answers each emitter strobe with a receiver pulse
// after a programmed delay and of a programmed width, giving a cycle-exact time of flight.
module lrf_echo_emulator #(
   parameter int WIDTH     = 8,
   parameter int PW_WIDTH  = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [WIDTH-1:0]     delay,
   input  logic [PW_WIDTH-1:0]  pulse_len,
   input  logic                 em_sensor,
   output logic                 rec_sensor,
   output logic                 busy,
   output logic                 overrun,
   output logic [CNT_WIDTH-1:0] echo_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      PULSE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  s1_q, s2_q, s3_q;
   logic [WIDTH-1:0]      dcnt_q, dcnt_d;
   logic [PW_WIDTH-1:0]   pcnt_q, pcnt_d;
   logic [PW_WIDTH-1:0]   plen_q, plen_d;
   logic                  rec_q, rec_d;
   logic                  busy_q;
   logic                  overrun_q, overrun_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  trig;

   assign trig = s2_q & ~s3_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         state_q   <= IDLE;
         dcnt_q    <= '0;
         pcnt_q    <= '0;
         plen_q    <= '0;
         rec_q     <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         s1_q      <= em_sensor;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         state_q   <= state_d;
         dcnt_q    <= dcnt_d;
         pcnt_q    <= pcnt_d;
         plen_q    <= plen_d;
         rec_q     <= rec_d;
         busy_q    <= (state_d != IDLE);
         overrun_q <= overrun_d;
         cnt_q     <= cnt_d;
      end
   end

   // Triggers are only accepted in IDLE; any trigger seen while an echo is in flight is an overrun.
   always_comb begin
      state_d   = state_q;
      dcnt_d    = dcnt_q;
      pcnt_d    = pcnt_q;
      plen_d    = plen_q;
      rec_d     = rec_q;
      overrun_d = overrun_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (trig && en) begin
               dcnt_d  = delay;
               plen_d  = (pulse_len == '0) ? PW_WIDTH'(1) : pulse_len;
               state_d = DELAY;
            end
         end
         DELAY: begin
            if (trig) overrun_d = 1'b1;
            if (dcnt_q == '0) begin
               rec_d   = 1'b1;
               pcnt_d  = plen_q - PW_WIDTH'(1);
               state_d = PULSE;
            end else begin
               dcnt_d = dcnt_q - WIDTH'(1);
            end
         end
         PULSE: begin
            if (trig) overrun_d = 1'b1;
            if (pcnt_q == '0) begin
               rec_d   = 1'b0;
               cnt_d   = cnt_q + CNT_WIDTH'(1);
               state_d = IDLE;
            end else begin
               pcnt_d = pcnt_q - PW_WIDTH'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rec_sensor = rec_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;
   assign echo_cnt   = cnt_q;

endmodule

// File: tb/tb_lrf_echo_emulator.sv
// Directed self-checking bench for lrf_echo_emulator; expected edges are hand-derived
// from T0, the first clock edge that samples em_sensor high.
module tb_lrf_echo_emulator;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] delay;
   logic [3:0] pulse_len;
   logic       em_sensor;
   logic       rec_sensor;
   logic       busy;
   logic       overrun;
   logic [7:0] echo_cnt;

   int checks = 0;
   int errors = 0;

   lrf_echo_emulator #(.WIDTH(8), .PW_WIDTH(4), .CNT_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .delay      (delay),
      .pulse_len  (pulse_len),
      .em_sensor  (em_sensor),
      .rec_sensor (rec_sensor),
      .busy       (busy),
      .overrun    (overrun),
      .echo_cnt   (echo_cnt)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic doReset();
      rst = 1'b1;
      em_sensor = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Leaves the bench just after edge T0 with em_sensor having been high for one period.
   task automatic pulse();
      @(negedge clk);
      em_sensor = 1'b1;
      @(negedge clk);
      em_sensor = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         em_sensor = ~em_sensor;
         @(negedge clk);
         checks++;
         if ({rec_sensor, busy, overrun} !== 3'b000 || echo_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset cycle %0d: rec=%b busy=%b ovr=%b cnt=%0d, required all 0",
                     i, rec_sensor, busy, overrun, echo_cnt);
         end
      end
      em_sensor = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      doReset();
      en = 1'b1; delay = 8'd16; pulse_len = 4'd2;
      pulse();
      for (int n = 1; n <= 23; n++) begin
         @(negedge clk);
         checks++;
         if (rec_sensor !== (n >= 19 && n <= 20) || busy !== (n >= 2 && n <= 20)) begin
            errors++;
            $display("[TB] FAIL basic T0+%0d: rec=%b busy=%b, required rec=%b busy=%b",
                     n, rec_sensor, busy, (n >= 19 && n <= 20), (n >= 2 && n <= 20));
         end
      end
      checks++;
      if (echo_cnt !== 8'd1 || overrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_cnt: cnt=%0d ovr=%b, required cnt=1 ovr=0", echo_cnt, overrun);
      end
   endtask

   task automatic test_zero();
      doReset();
      en = 1'b1; delay = 8'd0; pulse_len = 4'd0;
      pulse();
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         checks++;
         if (rec_sensor !== (n == 3) || busy !== (n >= 2 && n <= 3)) begin
            errors++;
            $display("[TB] FAIL zero T0+%0d: rec=%b busy=%b, required rec=%b busy=%b",
                     n, rec_sensor, busy, (n == 3), (n >= 2 && n <= 3));
         end
      end
      checks++;
      if (echo_cnt !== 8'd1) begin
         errors++;
         $display("[TB] FAIL zero_cnt: cnt=%0d, required 1", echo_cnt);
      end
   endtask

   task automatic test_overrun();
      doReset();
      en = 1'b1; delay = 8'd20; pulse_len = 4'd1;
      pulse();
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         checks++;
         if (rec_sensor !== (n == 23) || busy !== (n >= 2 && n <= 23) || overrun !== (n >= 7)) begin
            errors++;
            $display("[TB] FAIL overrun T0+%0d: rec=%b busy=%b ovr=%b, required rec=%b busy=%b ovr=%b",
                     n, rec_sensor, busy, overrun, (n == 23), (n >= 2 && n <= 23), (n >= 7));
         end
         if (n == 4) em_sensor = 1'b1;
         if (n == 5) em_sensor = 1'b0;
      end
      checks++;
      if (echo_cnt !== 8'd1 || overrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overrun_end: cnt=%0d ovr=%b, required cnt=1 ovr=1", echo_cnt, overrun);
      end
   endtask

   task automatic test_enable();
      doReset();
      en = 1'b0; delay = 8'd4; pulse_len = 4'd2;
      pulse();
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         checks++;
         if (busy !== 1'b0 || rec_sensor !== 1'b0) begin
            errors++;
            $display("[TB] FAIL en_off T0+%0d: busy=%b rec=%b, required 0 0", n, busy, rec_sensor);
         end
      end
      en = 1'b1;
      pulse();
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         checks++;
         if (rec_sensor !== (n >= 7 && n <= 8) || busy !== (n >= 2 && n <= 8)) begin
            errors++;
            $display("[TB] FAIL en_drop T0+%0d: rec=%b busy=%b, required rec=%b busy=%b",
                     n, rec_sensor, busy, (n >= 7 && n <= 8), (n >= 2 && n <= 8));
         end
         if (n == 2) en = 1'b0;
      end
      checks++;
      if (echo_cnt !== 8'd1 || overrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL en_cnt: cnt=%0d ovr=%b, required cnt=1 ovr=0", echo_cnt, overrun);
      end
   endtask

   task automatic test_reset_mid_and_wrap();
      doReset();
      en = 1'b1; delay = 8'd10; pulse_len = 4'd3;
      pulse();
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_busy: busy=%b, required 1", busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (rec_sensor !== 1'b0 || busy !== 1'b0 || echo_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset: rec=%b busy=%b cnt=%0d, required 0 0 0",
                  rec_sensor, busy, echo_cnt);
      end
      repeat (20) @(negedge clk);
      checks++;
      if (rec_sensor !== 1'b0 || busy !== 1'b0 || echo_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL mid_abort: rec=%b busy=%b cnt=%0d, required 0 0 0",
                  rec_sensor, busy, echo_cnt);
      end
      delay = 8'd1; pulse_len = 4'd1;
      for (int i = 1; i <= 256; i++) begin
         pulse();
         repeat (6) @(negedge clk);
         if (i == 1 || i == 255 || i == 256) begin
            checks++;
            if (echo_cnt !== 8'(i) || overrun !== 1'b0) begin
               errors++;
               $display("[TB] FAIL wrap echo %0d: cnt=%0d ovr=%b, required cnt=%0d ovr=0",
                        i, echo_cnt, overrun, i % 256);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; delay = 8'd0; pulse_len = 4'd0; em_sensor = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_zero();
      test_overrun();
      test_enable();
      test_reset_mid_and_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
